// File: rtl/dft_pkg.sv
// Shared definitions for the forward/inverse DFT engines: twiddle format,
// FSM states, RAM buffer-select encodings and 32-bit saturation.
package dft_pkg;

    localparam int unsigned Q    = 10;
    localparam int unsigned TW_W = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_RD   = 2'b01;
    localparam logic [1:0] SEL_WR   = 2'b10;

    function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
        if (v > 64'sd2147483647) begin
            return 32'sh7FFF_FFFF;
        end else if (v < -64'sd2147483648) begin
            return 32'sh8000_0000;
        end else begin
            return v[31:0];
        end
    endfunction

endpackage

// File: rtl/dft_twiddle_rom.sv
// Combinational Q10 twiddle ROM: W[m] = (cos, -sin) of 2*pi*m/SAMPLE, built
// from a 64-point quarter-wave cosine table by quadrant symmetry.
module dft_twiddle_rom
    import dft_pkg::*;
#(
    parameter int unsigned SAMPLE = 8,
    parameter int unsigned N_BIT  = 3
) (
    input  logic [N_BIT-1:0]        i_m,
    output logic signed [TW_W-1:0]  o_wr,
    output logic signed [TW_W-1:0]  o_wi
);

    localparam int unsigned STEP = 64 / SAMPLE;

    // round(1024*cos(2*pi*i/64)) for i = 0..16
    function automatic logic signed [TW_W-1:0] qcos(input logic [4:0] i);
        case (i)
            5'd0:    return 12'sd1024;
            5'd1:    return 12'sd1019;
            5'd2:    return 12'sd1004;
            5'd3:    return 12'sd980;
            5'd4:    return 12'sd946;
            5'd5:    return 12'sd903;
            5'd6:    return 12'sd851;
            5'd7:    return 12'sd792;
            5'd8:    return 12'sd724;
            5'd9:    return 12'sd650;
            5'd10:   return 12'sd569;
            5'd11:   return 12'sd483;
            5'd12:   return 12'sd392;
            5'd13:   return 12'sd297;
            5'd14:   return 12'sd200;
            5'd15:   return 12'sd100;
            default: return 12'sd0;
        endcase
    endfunction

    logic [5:0] w_j;
    logic [4:0] w_r;
    logic [4:0] w_rc;

    assign w_j  = 6'(i_m) * 6'(STEP);
    assign w_r  = {1'b0, w_j[3:0]};
    assign w_rc = 5'd16 - w_r;

    always_comb begin
        o_wr = qcos(w_r);
        o_wi = -qcos(w_rc);
        case (w_j[5:4])
            2'd0: begin o_wr =  qcos(w_r);  o_wi = -qcos(w_rc); end
            2'd1: begin o_wr = -qcos(w_rc); o_wi = -qcos(w_r);  end
            2'd2: begin o_wr = -qcos(w_r);  o_wi =  qcos(w_rc); end
            default: begin o_wr = qcos(w_rc); o_wi = qcos(w_r); end
        endcase
    end

endmodule

// File: rtl/dft_fwd.sv
// Direct-form forward DFT: reads N samples per bin from the shared RAM,
// accumulates one complex MAC per sample, writes the saturated bin back.
module dft_fwd
    import dft_pkg::*;
#(
    parameter int unsigned SAMPLE = 8,
    parameter int unsigned N_BIT  = 3,
    parameter int unsigned ACC_W  = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic signed [31:0]  i_data_in_re,
    input  logic signed [31:0]  i_data_in_im,
    output logic                o_done,
    output logic                o_rd_en,
    output logic                o_wr_en,
    output logic                o_ram_ctrl,
    output logic [1:0]          o_rd_sel,
    output logic [1:0]          o_wr_sel,
    output logic [N_BIT-1:0]    o_addr,
    output logic signed [31:0]  o_data_out_re,
    output logic signed [31:0]  o_data_out_im
);

    localparam int unsigned      CNT_W = N_BIT + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(SAMPLE - 1);

    state_t                  r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_k, w_k_nxt, r_n, w_n_nxt;
    logic signed [ACC_W-1:0] r_acc_re, w_acc_re_nxt, r_acc_im, w_acc_im_nxt;
    logic                    r_done, w_done_nxt;
    logic                    r_rd_en, w_rd_en_nxt, r_wr_en, w_wr_en_nxt;
    logic                    r_ram_ctrl, w_ram_ctrl_nxt;
    logic [1:0]              r_rd_sel, w_rd_sel_nxt, r_wr_sel, w_wr_sel_nxt;
    logic [N_BIT-1:0]        r_addr, w_addr_nxt;
    logic signed [31:0]      r_dout_re, w_dout_re_nxt, r_dout_im, w_dout_im_nxt;

    logic [N_BIT-1:0]        w_m;
    logic signed [TW_W-1:0]  w_wr, w_wi;
    logic signed [63:0]      w_rr, w_ii, w_ri, w_ir;
    logic signed [ACC_W-1:0] w_pr, w_pi;

    // twiddle index: (k*n) mod N is the low N_BIT bits of the product
    assign w_m = N_BIT'(r_k * r_n);

    dft_twiddle_rom #(
        .SAMPLE (SAMPLE),
        .N_BIT  (N_BIT)
    ) u_rom (
        .i_m  (w_m),
        .o_wr (w_wr),
        .o_wi (w_wi)
    );

    assign w_rr = 64'(i_data_in_re) * 64'(w_wr);
    assign w_ii = 64'(i_data_in_im) * 64'(w_wi);
    assign w_ri = 64'(i_data_in_re) * 64'(w_wi);
    assign w_ir = 64'(i_data_in_im) * 64'(w_wr);
    assign w_pr = ACC_W'((w_rr - w_ii) >>> Q);
    assign w_pi = ACC_W'((w_ri + w_ir) >>> Q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_n        <= '0;
            r_acc_re   <= '0;
            r_acc_im   <= '0;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_ram_ctrl <= 1'b0;
            r_rd_sel   <= SEL_NONE;
            r_wr_sel   <= SEL_NONE;
            r_addr     <= '0;
            r_dout_re  <= '0;
            r_dout_im  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_k        <= w_k_nxt;
            r_n        <= w_n_nxt;
            r_acc_re   <= w_acc_re_nxt;
            r_acc_im   <= w_acc_im_nxt;
            r_done     <= w_done_nxt;
            r_rd_en    <= w_rd_en_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_ram_ctrl <= w_ram_ctrl_nxt;
            r_rd_sel   <= w_rd_sel_nxt;
            r_wr_sel   <= w_wr_sel_nxt;
            r_addr     <= w_addr_nxt;
            r_dout_re  <= w_dout_re_nxt;
            r_dout_im  <= w_dout_im_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_n_nxt       = r_n;
        w_acc_re_nxt  = r_acc_re;
        w_acc_im_nxt  = r_acc_im;
        w_done_nxt    = r_done;
        w_rd_en_nxt   = 1'b0;
        w_wr_en_nxt   = 1'b0;
        w_rd_sel_nxt  = SEL_NONE;
        w_wr_sel_nxt  = SEL_NONE;
        w_addr_nxt    = r_addr;
        w_dout_re_nxt = r_dout_re;
        w_dout_im_nxt = r_dout_im;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_READ;
                    w_k_nxt     = '0;
                    w_n_nxt     = '0;
                    w_done_nxt  = 1'b0;
                end
            end
            S_READ: begin
                w_addr_nxt   = N_BIT'(r_n);
                w_rd_en_nxt  = 1'b1;
                w_rd_sel_nxt = SEL_RD;
                w_state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                w_state_nxt = S_MAC;
            end
            S_MAC: begin
                if (r_n == '0) begin
                    w_acc_re_nxt = w_pr;
                    w_acc_im_nxt = w_pi;
                end else begin
                    w_acc_re_nxt = r_acc_re + w_pr;
                    w_acc_im_nxt = r_acc_im + w_pi;
                end
                w_n_nxt     = r_n + 1'b1;
                w_state_nxt = (r_n == LAST) ? S_WRITE : S_READ;
            end
            S_WRITE: begin
                w_addr_nxt    = N_BIT'(r_k);
                w_wr_en_nxt   = 1'b1;
                w_wr_sel_nxt  = SEL_WR;
                w_dout_re_nxt = sat32(64'(r_acc_re));
                w_dout_im_nxt = sat32(64'(r_acc_im));
                w_n_nxt       = '0;
                w_k_nxt       = r_k + 1'b1;
                if (r_k == LAST) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_READ;
                end
            end
            S_DONE: begin
                if (!i_start) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_ram_ctrl_nxt = (w_state_nxt inside {S_READ, S_WAIT, S_MAC, S_WRITE});
    end

    assign o_done        = r_done;
    assign o_rd_en       = r_rd_en;
    assign o_wr_en       = r_wr_en;
    assign o_ram_ctrl    = r_ram_ctrl;
    assign o_rd_sel      = r_rd_sel;
    assign o_wr_sel      = r_wr_sel;
    assign o_addr        = r_addr;
    assign o_data_out_re = r_dout_re;
    assign o_data_out_im = r_dout_im;

endmodule

// File: tb/tb_dft_fwd.sv
// Bench for dft_fwd (N=8): directed vector table, random vectors against a
// floating-point-twiddle DFT model, handshake and mid-transform reset.
module tb_dft_fwd;

    localparam int N   = 8;
    localparam int BIN = 3 * N + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               i_start = 1'b0;
    logic signed [31:0] i_data_in_re = '0;
    logic signed [31:0] i_data_in_im = '0;
    logic               o_done, o_rd_en, o_wr_en, o_ram_ctrl;
    logic [1:0]         o_rd_sel, o_wr_sel;
    logic [2:0]         o_addr;
    logic signed [31:0] o_data_out_re, o_data_out_im;

    always #5 clk = ~clk;

    dft_fwd #(.SAMPLE(8), .N_BIT(3), .ACC_W(40)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_data_in_re  (i_data_in_re),
        .i_data_in_im  (i_data_in_im),
        .o_done        (o_done),
        .o_rd_en       (o_rd_en),
        .o_wr_en       (o_wr_en),
        .o_ram_ctrl    (o_ram_ctrl),
        .o_rd_sel      (o_rd_sel),
        .o_wr_sel      (o_wr_sel),
        .o_addr        (o_addr),
        .o_data_out_re (o_data_out_re),
        .o_data_out_im (o_data_out_im)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    longint mem_re[N], mem_im[N], exp_re[N], exp_im[N];
    longint tw_re[N], tw_im[N];

    // sample RAM: data valid the cycle after rd_en
    always @(posedge clk) begin
        if (o_rd_en) begin
            i_data_in_re <= 32'(mem_re[o_addr]);
            i_data_in_im <= 32'(mem_im[o_addr]);
        end
    end

    int     wq_addr[$], wq_cyc[$], rq_addr[$], rq_cyc[$];
    longint wq_re[$], wq_im[$];
    bit     overlap, sel_bad;

    always @(negedge clk) begin
        if (o_wr_en) begin
            wq_addr.push_back(int'(o_addr));
            wq_cyc.push_back(cyc);
            wq_re.push_back(longint'(o_data_out_re));
            wq_im.push_back(longint'(o_data_out_im));
        end
        if (o_rd_en) begin
            rq_addr.push_back(int'(o_addr));
            rq_cyc.push_back(cyc);
        end
        if (o_rd_en && o_wr_en) overlap = 1'b1;
        if (o_rd_sel != (o_rd_en ? 2'b01 : 2'b00) || o_wr_sel != (o_wr_en ? 2'b10 : 2'b00))
            sel_bad = 1'b1;
    end

    int n_vec = 0;
    int n_err = 0;
    int e0 = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Reference DFT straight from the definition, Q10-rounded twiddles
    task automatic model();
        longint sr, si, s;
        for (int k = 0; k < N; k++) begin
            sr = 0;
            si = 0;
            for (int n = 0; n < N; n++) begin
                int m;
                m  = (k * n) % N;
                sr += (mem_re[n] * tw_re[m] - mem_im[n] * tw_im[m]) >>> 10;
                si += (mem_re[n] * tw_im[m] + mem_im[n] * tw_re[m]) >>> 10;
            end
            s = sr;
            exp_re[k] = (s > 64'sd2147483647) ? 64'sd2147483647 :
                        (s < -64'sd2147483648) ? -64'sd2147483648 : s;
            s = si;
            exp_im[k] = (s > 64'sd2147483647) ? 64'sd2147483647 :
                        (s < -64'sd2147483648) ? -64'sd2147483648 : s;
        end
    endtask

    task automatic clear_q();
        wq_addr.delete(); wq_cyc.delete(); wq_re.delete(); wq_im.delete();
        rq_addr.delete(); rq_cyc.delete();
        overlap = 1'b0;
        sel_bad = 1'b0;
    endtask

    task automatic start_xfer(input bit keep);
        clear_q();
        @(negedge clk);
        i_start = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        chk("accept.done_low", longint'(o_done), 0);
        chk("accept.ram_ctrl", longint'(o_ram_ctrl), 1);
        if (!keep) i_start = 1'b0;
    endtask

    task automatic finish_xfer(input string tag);
        int t, bad;
        t = 0;
        while (!o_done && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("%s.done_cycle", tag), o_done ? longint'(cyc) : -1, longint'(e0 + N * BIN));
        @(negedge clk);
        chk($sformatf("%s.ram_ctrl_off", tag), longint'(o_ram_ctrl), 0);
        chk($sformatf("%s.done_held", tag), longint'(o_done), 1);
        chk($sformatf("%s.n_writes", tag), wq_addr.size(), N);
        for (int k = 0; k < N && k < wq_addr.size(); k++) begin
            chk($sformatf("%s.wr_addr[%0d]", tag, k), wq_addr[k], k);
            chk($sformatf("%s.wr_cyc[%0d]", tag, k), wq_cyc[k], e0 + (k + 1) * BIN);
            chk($sformatf("%s.re[%0d]", tag, k), wq_re[k], exp_re[k]);
            chk($sformatf("%s.im[%0d]", tag, k), wq_im[k], exp_im[k]);
        end
        chk($sformatf("%s.n_reads", tag), rq_addr.size(), N * N);
        bad = 0;
        foreach (rq_addr[i]) if (rq_addr[i] != i % N) bad++;
        chk($sformatf("%s.rd_order_errs", tag), bad, 0);
        chk($sformatf("%s.first_rd_cyc", tag), (rq_cyc.size() > 0) ? rq_cyc[0] : -1, e0 + 1);
        chk($sformatf("%s.rd_wr_overlap", tag), longint'(overlap), 0);
        chk($sformatf("%s.sel_errs", tag), longint'(sel_bad), 0);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk($sformatf("%s.ctrl_outs", tag),
            longint'({o_done, o_rd_en, o_wr_en, o_ram_ctrl, o_rd_sel, o_wr_sel, o_addr}), 0);
        chk($sformatf("%s.data_outs", tag), longint'({o_data_out_re, o_data_out_im}), 0);
    endtask

    typedef struct {
        string  name;
        longint x_re[N];
        longint x_im[N];
        longint e_re[N];
        longint e_im[N];
    } vec_t;

    vec_t tbl[4];

    task automatic load_tbl(input int i);
        for (int n = 0; n < N; n++) begin
            mem_re[n] = tbl[i].x_re[n];
            mem_im[n] = tbl[i].x_im[n];
            exp_re[n] = tbl[i].e_re[n];
            exp_im[n] = tbl[i].e_im[n];
        end
    endtask

    initial begin
        int n_rd;
        for (int m = 0; m < N; m++) begin
            tw_re[m] = longint'(int'(1024.0 * $cos(2.0 * 3.14159265358979 * m / N)));
            tw_im[m] = longint'(int'(-1024.0 * $sin(2.0 * 3.14159265358979 * m / N)));
        end

        // Floor-shift of each product biases the non-trivial odd bins by -2
        tbl[0].name = "impulse";
        tbl[0].x_re = '{1024, 0, 0, 0, 0, 0, 0, 0};
        tbl[0].x_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[0].e_re = '{1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024};
        tbl[0].e_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1].name = "constant";
        tbl[1].x_re = '{100, 100, 100, 100, 100, 100, 100, 100};
        tbl[1].x_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1].e_re = '{800, -2, 0, -2, 0, -2, 0, -2};
        tbl[1].e_im = '{0, -2, 0, -2, 0, -2, 0, -2};
        tbl[2].name = "nyquist";
        tbl[2].x_re = '{1000, -1000, 1000, -1000, 1000, -1000, 1000, -1000};
        tbl[2].x_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].e_re = '{0, -2, 0, -2, 8000, -2, 0, -2};
        tbl[2].e_im = '{0, -2, 0, -2, 0, -2, 0, -2};
        tbl[3].name = "saturate";
        tbl[3].x_re = '{2147483647, 2147483647, 2147483647, 2147483647,
                        2147483647, 2147483647, 2147483647, 2147483647};
        tbl[3].x_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].e_re = '{2147483647, -2, 0, -2, 0, -2, 0, -2};
        tbl[3].e_im = '{0, -2, 0, -2, 0, -2, 0, -2};

        repeat (3) @(negedge clk);
        chk_outs_zero("reset");
        rst = 1'b0;

        foreach (tbl[i]) begin
            load_tbl(i);
            start_xfer(1'b0);
            finish_xfer(tbl[i].name);
        end

        // random vectors; the last one keeps start high through DONE
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < N; n++) begin
                if (r == 0) begin
                    mem_re[n] = longint'($urandom_range(4000, 0)) - 2000;
                    mem_im[n] = longint'($urandom_range(4000, 0)) - 2000;
                end else begin
                    mem_re[n] = longint'($signed($urandom()));
                    mem_im[n] = longint'($signed($urandom()));
                end
            end
            model();
            start_xfer(r == 2);
            finish_xfer($sformatf("random%0d", r));
        end

        n_rd = rq_addr.size();
        repeat (50) @(negedge clk);
        chk("hold.no_reads", rq_addr.size(), n_rd);
        chk("hold.done", longint'(o_done), 1);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle.done_high", longint'(o_done), 1);

        // restart, then reset 60 cycles into the transform
        start_xfer(1'b0);
        repeat (2) @(negedge clk);
        chk("restart.n_reads", rq_addr.size(), 1);
        chk("restart.addr0", (rq_addr.size() > 0) ? rq_addr[0] : -1, 0);
        chk("restart.rd_cyc", (rq_cyc.size() > 0) ? rq_cyc[0] : -1, e0 + 1);
        while (cyc < e0 + 60) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_outs_zero("midreset");
        chk("midreset.partial_writes", wq_addr.size(), 2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_q();
        repeat (20) @(negedge clk);
        chk("post_reset.reads", rq_addr.size(), 0);
        chk("post_reset.writes", wq_addr.size(), 0);
        chk("post_reset.done", longint'(o_done), 0);

        load_tbl(0);
        start_xfer(1'b0);
        finish_xfer("impulse_rerun");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
